// File: rtl/zap_regf_pkg.sv
// Shared register map, mode encodings, CPSR layout and sequencer states for the
// banked register file.
package zap_regf_pkg;

    localparam int ARCH_PC      = 15;
    localparam int PHY_PC       = 15;
    localparam int PHY_CPSR     = 16;
    localparam int PHY_FIQ_R8   = 17;
    localparam int PHY_FIQ_R14  = 23;
    localparam int PHY_IRQ_R13  = 24;
    localparam int PHY_IRQ_R14  = 25;
    localparam int PHY_SVC_R13  = 26;
    localparam int PHY_SVC_R14  = 27;
    localparam int PHY_ABT_R13  = 28;
    localparam int PHY_ABT_R14  = 29;
    localparam int PHY_UND_R13  = 30;
    localparam int PHY_UND_R14  = 31;
    localparam int PHY_SPSR_FIQ = 32;
    localparam int PHY_SPSR_IRQ = 33;
    localparam int PHY_SPSR_SVC = 34;
    localparam int PHY_SPSR_ABT = 35;
    localparam int PHY_SPSR_UND = 36;

    localparam logic [4:0] MODE_USR = 5'h10;
    localparam logic [4:0] MODE_FIQ = 5'h11;
    localparam logic [4:0] MODE_IRQ = 5'h12;
    localparam logic [4:0] MODE_SVC = 5'h13;
    localparam logic [4:0] MODE_ABT = 5'h17;
    localparam logic [4:0] MODE_UND = 5'h1B;
    localparam logic [4:0] MODE_SYS = 5'h1F;

    localparam int CPSR_I       = 7;
    localparam int CPSR_F       = 6;
    localparam int CPSR_T       = 5;
    localparam int CPSR_MODE_HI = 4;
    localparam int CPSR_MODE_LO = 0;
    localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

    localparam int EXC_DABT = 0;
    localparam int EXC_FIQ  = 1;
    localparam int EXC_IRQ  = 2;
    localparam int EXC_IABT = 3;
    localparam int EXC_SWI  = 4;
    localparam int EXC_UND  = 5;
    localparam int EXC_NUM  = 6;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_ENTRY} regf_state_t;

    function automatic logic [4:0] excTargetMode(input logic [2:0] src);
        case (src)
            3'd0, 3'd3: return MODE_ABT;
            3'd1:       return MODE_FIQ;
            3'd2:       return MODE_IRQ;
            3'd4:       return MODE_SVC;
            default:    return MODE_UND;
        endcase
    endfunction

    function automatic int bankedLr(input logic [4:0] mode);
        case (mode)
            MODE_FIQ: return PHY_FIQ_R14;
            MODE_IRQ: return PHY_IRQ_R14;
            MODE_SVC: return PHY_SVC_R14;
            MODE_ABT: return PHY_ABT_R14;
            default:  return PHY_UND_R14;
        endcase
    endfunction

    // USR, SYS and unrecognised modes have no SPSR; -1 flags that case.
    function automatic int bankedSpsr(input logic [4:0] mode);
        case (mode)
            MODE_FIQ: return PHY_SPSR_FIQ;
            MODE_IRQ: return PHY_SPSR_IRQ;
            MODE_SVC: return PHY_SPSR_SVC;
            MODE_ABT: return PHY_SPSR_ABT;
            MODE_UND: return PHY_SPSR_UND;
            default:  return -1;
        endcase
    endfunction

endpackage

// File: rtl/zap_exc_prio_enc.sv
// Fixed-priority exception encoder: bit 0 of the request vector wins.
module zap_exc_prio_enc
    import zap_regf_pkg::*;
(
    input  logic [EXC_NUM-1:0] i_req,
    output logic [EXC_NUM-1:0] o_grant,
    output logic [2:0]         o_src,
    output logic               o_valid
);

    always_comb begin
        o_grant = '0;
        o_src   = '0;
        o_valid = 1'b0;
        for (int i = EXC_NUM - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant = EXC_NUM'(1) << i;
                o_src   = 3'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zap_banked_regfile.sv
// Multi-port banked register file owning PC/CPSR, with post-reset clear sweep
// and a one-cycle exception entry sequencer.
module zap_banked_regfile
    import zap_regf_pkg::*;
#(
    parameter int                  DATA_WDT = 32,
    parameter int                  PHY_REGS = 46,
    parameter int                  RD_PORTS = 4,
    parameter int                  WR_PORTS = 2,
    parameter int                  BYPASS   = 1,
    parameter logic [DATA_WDT-1:0] RESET_PC = '0,
    localparam int                 IDX      = $clog2(PHY_REGS)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [RD_PORTS*IDX-1:0]      i_rd_index,
    output logic [RD_PORTS*DATA_WDT-1:0] o_rd_data,
    input  logic [WR_PORTS-1:0]          i_wr_en,
    input  logic [WR_PORTS*IDX-1:0]      i_wr_index,
    input  logic [WR_PORTS*DATA_WDT-1:0] i_wr_data,
    input  logic [31:0]                  i_flags,
    input  logic                         i_flags_en,
    input  logic                         i_flag_restore,
    input  logic                         i_pc_hold,
    input  logic                         i_pc_load,
    input  logic [DATA_WDT-1:0]          i_pc_load_value,
    input  logic [EXC_NUM-1:0]           i_exc_req,
    input  logic [EXC_NUM*DATA_WDT-1:0]  i_exc_vector,
    input  logic [DATA_WDT-1:0]          i_pc_buf,
    output logic [DATA_WDT-1:0]          o_pc,
    output logic [31:0]                  o_cpsr,
    output logic                         o_ready,
    output logic                         o_busy,
    output logic                         o_clear,
    output logic                         o_fiq_ack,
    output logic                         o_irq_ack
);

    logic [DATA_WDT-1:0] r_mem [PHY_REGS];
    regf_state_t         r_state;
    logic [IDX-1:0]      r_cnt;
    logic [DATA_WDT-1:0] r_pc;
    logic [31:0]         r_cpsr;
    logic [2:0]          r_excSrc;
    logic [DATA_WDT-1:0] r_excVec;
    logic [DATA_WDT-1:0] r_excPcBuf;
    logic [31:0]         r_excCpsr;
    logic                r_ready;
    logic                r_busy;
    logic                r_fiqAck;
    logic                r_irqAck;

    logic [EXC_NUM-1:0]  w_grant;
    logic [2:0]          w_src;
    logic                w_excValid;
    logic                w_commit;
    logic                w_pcWr;
    logic [DATA_WDT-1:0] w_pcWrData;
    logic [DATA_WDT-1:0] w_pcNext;
    logic [31:0]         w_cpsrNext;
    logic [DATA_WDT-1:0] w_vecSel;
    logic [4:0]          w_tgtMode;
    logic [DATA_WDT-1:0] w_lrValue;
    logic [31:0]         w_entryCpsr;

    zap_exc_prio_enc u_prio (
        .i_req   (i_exc_req),
        .o_grant (w_grant),
        .o_src   (w_src),
        .o_valid (w_excValid)
    );

    // A pending exception request swallows every architectural update that cycle.
    assign w_commit = (r_state == ST_RUN) && !w_excValid;

    always_comb begin
        w_pcWr     = 1'b0;
        w_pcWrData = '0;
        w_vecSel   = '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            if (i_wr_en[p] && (i_wr_index[p*IDX +: IDX] == IDX'(ARCH_PC))) begin
                w_pcWr     = 1'b1;
                w_pcWrData = i_wr_data[p*DATA_WDT +: DATA_WDT];
            end
        end
        for (int k = 0; k < EXC_NUM; k++) begin
            if (w_grant[k]) w_vecSel = i_exc_vector[k*DATA_WDT +: DATA_WDT];
        end
    end

    always_comb begin
        int spsrIdx;
        spsrIdx    = bankedSpsr(r_cpsr[CPSR_MODE_HI:CPSR_MODE_LO]);
        w_cpsrNext = r_cpsr;
        if (w_pcWr && i_flag_restore) begin
            if (spsrIdx >= 0) w_cpsrNext = r_mem[IDX'(spsrIdx)][31:0];
        end else if (i_flags_en) begin
            w_cpsrNext = i_flags;
        end

        if (w_pcWr)         w_pcNext = w_pcWrData;
        else if (i_pc_load) w_pcNext = i_pc_load_value;
        else if (i_pc_hold) w_pcNext = r_pc;
        else                w_pcNext = r_pc + (r_cpsr[CPSR_T] ? DATA_WDT'(2) : DATA_WDT'(4));
    end

    // Return address: data aborts point past the faulting instruction, the rest at it.
    always_comb begin
        w_tgtMode = excTargetMode(r_excSrc);
        if (r_excSrc == 3'(EXC_DABT))
            w_lrValue = r_excPcBuf + (r_excCpsr[CPSR_T] ? DATA_WDT'(4) : DATA_WDT'(0));
        else
            w_lrValue = r_excCpsr[CPSR_T] ? r_excPcBuf : r_excPcBuf - DATA_WDT'(4);
        w_entryCpsr         = r_excCpsr;
        w_entryCpsr[CPSR_I] = 1'b1;
        w_entryCpsr[CPSR_F] = r_excCpsr[CPSR_F] | (r_excSrc == 3'(EXC_FIQ));
        w_entryCpsr[CPSR_T] = 1'b0;
        w_entryCpsr[CPSR_MODE_HI:CPSR_MODE_LO] = w_tgtMode;
    end

    always_comb begin
        o_rd_data = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            o_rd_data[r*DATA_WDT +: DATA_WDT] = r_mem[i_rd_index[r*IDX +: IDX]];
            if ((BYPASS != 0) && w_commit) begin
                for (int p = 0; p < WR_PORTS; p++) begin
                    if (i_wr_en[p] && (i_wr_index[p*IDX +: IDX] == i_rd_index[r*IDX +: IDX]))
                        o_rd_data[r*DATA_WDT +: DATA_WDT] = i_wr_data[p*DATA_WDT +: DATA_WDT];
                end
            end
        end
    end

    // The array itself has no reset so it can map onto RAM; INIT sweeps it instead.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            case (r_state)
                ST_INIT:  r_mem[r_cnt] <= '0;
                ST_ENTRY: begin
                    r_mem[IDX'(bankedLr(w_tgtMode))]   <= w_lrValue;
                    r_mem[IDX'(bankedSpsr(w_tgtMode))] <= DATA_WDT'(r_excCpsr);
                end
                default: begin
                    if (w_commit) begin
                        for (int p = 0; p < WR_PORTS; p++) begin
                            if (i_wr_en[p])
                                r_mem[i_wr_index[p*IDX +: IDX]] <= i_wr_data[p*DATA_WDT +: DATA_WDT];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_INIT;
            r_cnt      <= '0;
            r_pc       <= '0;
            r_cpsr     <= '0;
            r_excSrc   <= '0;
            r_excVec   <= '0;
            r_excPcBuf <= '0;
            r_excCpsr  <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_fiqAck   <= 1'b0;
            r_irqAck   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + IDX'(1);
                    if (r_cnt == IDX'(PHY_REGS - 1)) begin
                        r_state <= ST_RUN;
                        r_pc    <= RESET_PC;
                        r_cpsr  <= CPSR_RESET;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_excValid) begin
                        r_state    <= ST_ENTRY;
                        r_excSrc   <= w_src;
                        r_excVec   <= w_vecSel;
                        r_excPcBuf <= i_pc_buf;
                        r_excCpsr  <= r_cpsr;
                        r_busy     <= 1'b1;
                        r_fiqAck   <= w_grant[EXC_FIQ];
                        r_irqAck   <= w_grant[EXC_IRQ];
                    end else begin
                        r_pc   <= w_pcNext;
                        r_cpsr <= w_cpsrNext;
                    end
                end
                ST_ENTRY: begin
                    r_state  <= ST_RUN;
                    r_pc     <= r_excVec;
                    r_cpsr   <= w_entryCpsr;
                    r_busy   <= 1'b0;
                    r_fiqAck <= 1'b0;
                    r_irqAck <= 1'b0;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_pc      = r_pc;
    assign o_cpsr    = r_cpsr;
    assign o_ready   = r_ready;
    assign o_busy    = r_busy;
    assign o_fiq_ack = r_fiqAck;
    assign o_irq_ack = r_irqAck;
    assign o_clear   = r_busy || (w_commit && w_pcWr);

endmodule

// File: tb/tb_zap_banked_regfile.sv
// Randomised bench for zap_banked_regfile against a cycle-level behavioural
// model of the register file, plus directed banking and reset scenarios.
module tb_zap_banked_regfile;
    import zap_regf_pkg::*;

    localparam int W    = 32;
    localparam int NREG = 46;
    localparam int IDXW = 6;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int PH_INIT  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_ENTRY = 2;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic [NRD*IDXW-1:0] i_rd_index;
    logic [NRD*W-1:0]  o_rd_data;
    logic [NWR-1:0]    i_wr_en;
    logic [NWR*IDXW-1:0] i_wr_index;
    logic [NWR*W-1:0]  i_wr_data;
    logic [31:0]       i_flags;
    logic              i_flags_en;
    logic              i_flag_restore;
    logic              i_pc_hold;
    logic              i_pc_load;
    logic [W-1:0]      i_pc_load_value;
    logic [5:0]        i_exc_req;
    logic [6*W-1:0]    i_exc_vector;
    logic [W-1:0]      i_pc_buf;
    logic [W-1:0]      o_pc;
    logic [31:0]       o_cpsr;
    logic              o_ready;
    logic              o_busy;
    logic              o_clear;
    logic              o_fiq_ack;
    logic              o_irq_ack;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] mMem [NREG];
    logic [31:0] mPc;
    logic [31:0] mCpsr;
    int          mPhase;
    int          mCnt;
    int          mSrc;
    logic [31:0] mVec;
    logic [31:0] mBuf;
    logic [31:0] mSavedCpsr;

    zap_banked_regfile #(
        .DATA_WDT (W),
        .PHY_REGS (NREG),
        .RD_PORTS (NRD),
        .WR_PORTS (NWR),
        .BYPASS   (1),
        .RESET_PC ('0)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_rd_index      (i_rd_index),
        .o_rd_data       (o_rd_data),
        .i_wr_en         (i_wr_en),
        .i_wr_index      (i_wr_index),
        .i_wr_data       (i_wr_data),
        .i_flags         (i_flags),
        .i_flags_en      (i_flags_en),
        .i_flag_restore  (i_flag_restore),
        .i_pc_hold       (i_pc_hold),
        .i_pc_load       (i_pc_load),
        .i_pc_load_value (i_pc_load_value),
        .i_exc_req       (i_exc_req),
        .i_exc_vector    (i_exc_vector),
        .i_pc_buf        (i_pc_buf),
        .o_pc            (o_pc),
        .o_cpsr          (o_cpsr),
        .o_ready         (o_ready),
        .o_busy          (o_busy),
        .o_clear         (o_clear),
        .o_fiq_ack       (o_fiq_ack),
        .o_irq_ack       (o_irq_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [4:0] tbTargetMode(input int src);
        case (src)
            0, 3:    return MODE_ABT;
            1:       return MODE_FIQ;
            2:       return MODE_IRQ;
            4:       return MODE_SVC;
            default: return MODE_UND;
        endcase
    endfunction

    function automatic int tbLrIndex(input logic [4:0] mode);
        case (mode)
            MODE_FIQ: return PHY_FIQ_R14;
            MODE_IRQ: return PHY_IRQ_R14;
            MODE_SVC: return PHY_SVC_R14;
            MODE_ABT: return PHY_ABT_R14;
            default:  return PHY_UND_R14;
        endcase
    endfunction

    function automatic int tbSpsrIndex(input logic [4:0] mode);
        case (mode)
            MODE_FIQ: return PHY_SPSR_FIQ;
            MODE_IRQ: return PHY_SPSR_IRQ;
            MODE_SVC: return PHY_SPSR_SVC;
            MODE_ABT: return PHY_SPSR_ABT;
            MODE_UND: return PHY_SPSR_UND;
            default:  return -1;
        endcase
    endfunction

    function automatic int wrIdx(input int p);
        return int'(i_wr_index[p*IDXW +: IDXW]);
    endfunction

    task automatic idleInputs();
        i_rd_index      = '0;
        i_wr_en         = '0;
        i_wr_index      = '0;
        i_wr_data       = '0;
        i_flags         = '0;
        i_flags_en      = 1'b0;
        i_flag_restore  = 1'b0;
        i_pc_hold       = 1'b0;
        i_pc_load       = 1'b0;
        i_pc_load_value = '0;
        i_exc_req       = '0;
        i_pc_buf        = '0;
        for (int k = 0; k < 6; k++) i_exc_vector[k*W +: W] = 32'h1000 + 32'(k * 8);
    endtask

    task automatic applyStimulus();
        logic [31:0] rnd;
        logic [4:0]  modes [7];
        modes = '{MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND, MODE_SYS};
        rnd = $urandom;
        for (int r = 0; r < NRD; r++) i_rd_index[r*IDXW +: IDXW] = 6'($urandom_range(0, NREG - 1));
        i_wr_en = 2'($urandom_range(0, 3));
        for (int p = 0; p < NWR; p++) begin
            i_wr_index[p*IDXW +: IDXW] = ($urandom_range(0, 7) == 0) ? 6'(ARCH_PC) : 6'($urandom_range(0, NREG - 1));
            i_wr_data[p*W +: W] = $urandom;
        end
        i_flags         = {rnd[31:5], modes[$urandom_range(0, 6)]};
        i_flags_en      = ($urandom_range(0, 5) == 0);
        i_flag_restore  = 1'($urandom_range(0, 1));
        i_pc_hold       = ($urandom_range(0, 3) == 0);
        i_pc_load       = ($urandom_range(0, 7) == 0);
        i_pc_load_value = $urandom;
        i_exc_req       = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
        i_pc_buf        = $urandom;
        for (int k = 0; k < 6; k++) i_exc_vector[k*W +: W] = $urandom;
        i_reset         = ($urandom_range(0, 399) == 0);
    endtask

    // Compare every observable output against the model for the current cycle.
    task automatic checkCycle();
        logic        anyPcWr;
        logic        bypassOn;
        logic [31:0] expRd;
        int          ri;
        bypassOn = (mPhase == PH_RUN) && (i_exc_req == 6'd0);
        anyPcWr  = 1'b0;
        for (int p = 0; p < NWR; p++)
            if (i_wr_en[p] && wrIdx(p) == ARCH_PC) anyPcWr = 1'b1;
        checkOutput("ready",  32'(o_ready),   32'(mPhase != PH_INIT));
        checkOutput("busy",   32'(o_busy),    32'(mPhase == PH_ENTRY));
        checkOutput("clear",  32'(o_clear),   32'((mPhase == PH_ENTRY) || (bypassOn && anyPcWr)));
        checkOutput("fiqAck", 32'(o_fiq_ack), 32'((mPhase == PH_ENTRY) && (mSrc == EXC_FIQ)));
        checkOutput("irqAck", 32'(o_irq_ack), 32'((mPhase == PH_ENTRY) && (mSrc == EXC_IRQ)));
        checkOutput("pc",     o_pc,   mPc);
        checkOutput("cpsr",   o_cpsr, mCpsr);
        if (mPhase != PH_INIT) begin
            for (int r = 0; r < NRD; r++) begin
                ri    = int'(i_rd_index[r*IDXW +: IDXW]);
                expRd = mMem[ri];
                if (bypassOn)
                    for (int p = 0; p < NWR; p++)
                        if (i_wr_en[p] && wrIdx(p) == ri) expRd = i_wr_data[p*W +: W];
                checkOutput("rdData", o_rd_data[r*W +: W], expRd);
            end
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic modelStep();
        logic        pcWr;
        logic [31:0] pcVal;
        logic [31:0] newPc;
        logic [31:0] newCpsr;
        logic [4:0]  tgt;
        logic [31:0] lr;
        int          s;
        if (i_reset) begin
            mPhase = PH_INIT;
            mCnt   = 0;
            mPc    = '0;
            mCpsr  = '0;
            mSrc   = -1;
            return;
        end
        case (mPhase)
            PH_INIT: begin
                mMem[mCnt] = '0;
                if (mCnt == NREG - 1) begin
                    mPhase = PH_RUN;
                    mPc    = '0;
                    mCpsr  = 32'h0000_00D3;
                end
                mCnt++;
            end
            PH_RUN: begin
                if (i_exc_req != 6'd0) begin
                    for (int i = 5; i >= 0; i--) if (i_exc_req[i]) mSrc = i;
                    mVec       = i_exc_vector[mSrc*W +: W];
                    mBuf       = i_pc_buf;
                    mSavedCpsr = mCpsr;
                    mPhase     = PH_ENTRY;
                end else begin
                    pcWr  = 1'b0;
                    pcVal = '0;
                    for (int p = 0; p < NWR; p++)
                        if (i_wr_en[p] && wrIdx(p) == ARCH_PC) begin
                            pcWr  = 1'b1;
                            pcVal = i_wr_data[p*W +: W];
                        end
                    newCpsr = mCpsr;
                    if (pcWr && i_flag_restore) begin
                        s = tbSpsrIndex(mCpsr[4:0]);
                        if (s >= 0) newCpsr = mMem[s];
                    end else if (i_flags_en) begin
                        newCpsr = i_flags;
                    end
                    if (pcWr)           newPc = pcVal;
                    else if (i_pc_load) newPc = i_pc_load_value;
                    else if (i_pc_hold) newPc = mPc;
                    else                newPc = mPc + (mCpsr[5] ? 32'd2 : 32'd4);
                    for (int p = 0; p < NWR; p++)
                        if (i_wr_en[p]) mMem[wrIdx(p)] = i_wr_data[p*W +: W];
                    mPc   = newPc;
                    mCpsr = newCpsr;
                end
            end
            default: begin
                tgt = tbTargetMode(mSrc);
                if (mSrc == EXC_DABT) lr = mBuf + (mSavedCpsr[5] ? 32'd4 : 32'd0);
                else                  lr = mBuf - (mSavedCpsr[5] ? 32'd0 : 32'd4);
                mMem[tbLrIndex(tgt)]   = lr;
                mMem[tbSpsrIndex(tgt)] = mSavedCpsr;
                mCpsr  = {mSavedCpsr[31:8], 1'b1, mSavedCpsr[6] | (mSrc == EXC_FIQ), 1'b0, tgt};
                mPc    = mVec;
                mPhase = PH_RUN;
                mSrc   = -1;
            end
        endcase
    endtask

    task automatic runCycle();
        @(negedge i_clk);
        checkCycle();
        @(posedge i_clk);
        modelStep();
        #1;
    endtask

    initial begin
        int cycles;
        mSrc    = -1;
        i_reset = 1'b1;
        idleInputs();
        @(posedge i_clk);
        modelStep();
        #1;
        runCycle();
        runCycle();

        i_reset = 1'b0;
        repeat (NREG - 1) runCycle();
        checkOutput("readyBeforeInitDone", 32'(o_ready), 32'd0);
        runCycle();
        checkOutput("readyAfterInit", 32'(o_ready), 32'd1);
        checkOutput("cpsrAfterInit", o_cpsr, 32'h0000_00D3);
        checkOutput("pcAfterInit", o_pc, 32'h0);

        idleInputs();
        i_pc_hold  = 1'b1;
        i_wr_en    = 2'b11;
        i_wr_index = {6'd3, 6'd3};
        i_wr_data  = {32'hB, 32'hA};
        i_rd_index[IDXW-1:0] = 6'd3;
        #3 checkOutput("bypassCollide", o_rd_data[W-1:0], 32'hB);
        runCycle();
        idleInputs();
        i_pc_hold = 1'b1;
        i_rd_index[IDXW-1:0] = 6'd3;
        #3 checkOutput("storedCollide", o_rd_data[W-1:0], 32'hB);
        runCycle();

        idleInputs();
        i_exc_req = 6'b000110;
        i_pc_buf  = 32'h108;
        runCycle();
        idleInputs();
        #3 checkOutput("fiqAckPulse", 32'(o_fiq_ack), 32'd1);
        checkOutput("irqAckQuiet", 32'(o_irq_ack), 32'd0);
        runCycle();
        idleInputs();
        i_pc_hold = 1'b1;
        i_rd_index = {6'd0, 6'd0, 6'(PHY_SPSR_FIQ), 6'(PHY_FIQ_R14)};
        #3 checkOutput("fiqLr", o_rd_data[W-1:0], 32'h104);
        checkOutput("fiqSpsr", o_rd_data[2*W-1:W], 32'hD3);
        checkOutput("fiqCpsr", o_cpsr, 32'hD1);
        checkOutput("fiqPc", o_pc, 32'h1008);
        runCycle();

        idleInputs();
        i_pc_hold  = 1'b1;
        i_flags_en = 1'b1;
        i_flags    = 32'hF3;
        runCycle();
        idleInputs();
        i_exc_req = 6'b000001;
        i_pc_buf  = 32'h200;
        runCycle();
        idleInputs();
        runCycle();
        idleInputs();
        i_pc_hold = 1'b1;
        i_rd_index = {6'd0, 6'd0, 6'(PHY_SPSR_ABT), 6'(PHY_ABT_R14)};
        #3 checkOutput("dabtThumbLr", o_rd_data[W-1:0], 32'h204);
        checkOutput("dabtSpsr", o_rd_data[2*W-1:W], 32'hF3);
        checkOutput("dabtCpsr", o_cpsr, 32'hD7);
        runCycle();

        idleInputs();
        i_exc_req = 6'b100000;
        i_pc_buf  = 32'h300;
        runCycle();
        idleInputs();
        runCycle();
        idleInputs();
        i_pc_hold = 1'b1;
        i_rd_index = {6'd0, 6'd0, 6'(PHY_FIQ_R14), 6'(PHY_UND_R14)};
        #3 checkOutput("undLr", o_rd_data[W-1:0], 32'h2FC);
        checkOutput("fiqBankUntouched", o_rd_data[2*W-1:W], 32'h104);
        checkOutput("undCpsr", o_cpsr, 32'hDB);
        runCycle();

        idleInputs();
        i_exc_req = 6'b000100;
        i_pc_buf  = 32'h400;
        runCycle();
        idleInputs();
        runCycle();
        idleInputs();
        i_wr_en        = 2'b01;
        i_wr_index     = {6'd0, 6'(ARCH_PC)};
        i_wr_data      = {32'h0, 32'h40};
        i_flag_restore = 1'b1;
        i_flags_en     = 1'b1;
        i_flags        = 32'h10;
        #3 checkOutput("restoreClear", 32'(o_clear), 32'd1);
        runCycle();
        idleInputs();
        i_pc_hold = 1'b1;
        #3 checkOutput("restorePc", o_pc, 32'h40);
        checkOutput("restoreCpsr", o_cpsr, 32'hDB);
        runCycle();

        idleInputs();
        i_exc_req = 6'b000010;
        runCycle();
        idleInputs();
        i_reset = 1'b1;
        #3 checkOutput("ackInEntry", 32'(o_fiq_ack), 32'd1);
        runCycle();
        #3 checkOutput("ackAfterReset", 32'(o_fiq_ack), 32'd0);
        checkOutput("busyAfterReset", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
        cycles = 0;
        while (!o_ready && cycles < 100) begin
            runCycle();
            cycles++;
        end
        checkOutput("reinitCycles", 32'(cycles), 32'd46);

        repeat (1500) begin
            applyStimulus();
            runCycle();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
